stream_consumer: RTL and testbench
==================================

Name: stream_consumer

Overview:
- Receiving end of the two-channel producer address stream: per-channel inputs are address, id and valid, with stall as backpressure and flush/flush_id as cancellation.
- Buffers each channel in a DEPTH-entry FIFO and back-pressures via out_stall_x.
- Cancels buffered or arriving beats whose id matches a flush request.
- Merges both channels round-robin onto one ready/valid output toward the downstream checker.

Parameters:
- DEPTH, 4, entries per channel FIFO; power of two, at least 2.
- ADDRESS_WIDTH, from defines.vh, address width.
- ID_WIDTH, from defines.vh (8), id width.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous reset, active-low
- in_address_1  in  ADDRESS_WIDTH  ch1 beat address
- in_id_1  in  ID_WIDTH  ch1 beat id
- in_valid_1  in  1  ch1 beat valid
- out_stall_1  out  1  ch1 backpressure
- flush_1  in  1  ch1 flush strobe
- flush_id_1  in  ID_WIDTH  ch1 id to cancel
- in_address_2, in_id_2, in_valid_2, out_stall_2, flush_2, flush_id_2: same as ch1, for ch2
- out_address  out  ADDRESS_WIDTH  merged beat address
- out_id  out  ID_WIDTH  merged beat id
- out_channel  out  1  source channel of out beat; 0 = ch1, 1 = ch2
- out_valid  out  1  merged beat valid
- in_ready  in  1  downstream accepts
- drop_count  out  8  saturating count of flushed beats

Behaviour:
- Reset (reset_n low at clk edge):
  - FIFOs empty, kill bits clear.
  - out_stall_x=0, out_valid=0, drop_count=0.
  - last_grant=ch2, so ch1 wins first.
  - Reset mid-operation discards all buffered beats.
- Stall: out_stall_x = (count_x == DEPTH).
  - Registered-state only; no combinational path from any input.
- Accept: beat captured at edge when in_valid_x && !out_stall_x. The producer advances on the same edge.
  - Full FIFO never pushes, even if popping that cycle.
  - Push and pop of the same FIFO in one cycle: count unchanged.
- Entry: {address, id, kill}.
- Flush (flush_x high at edge), applies only to channel x's FIFO:
  - Every occupied entry with id == flush_id_x gets kill=1.
  - A beat accepted that same edge with matching id is written with kill=1.
  - An entry popped by the output handshake on the flush edge is delivered, not killed.
- Head discard: a killed head is popped internally, needs no ready, one entry per channel per cycle.
  - Both channels may discard in the same cycle.
  - drop_count += number discarded, saturating at 255.
- Output: combinational from the granted head.
  - Live head = non-empty and kill=0.
  - Only one channel live: it is granted.
  - Both live: grant the channel other than last_grant.
  - out_valid = granted head live.
  - Pop when out_valid && in_ready; last_grant updates only on a pop.
  - out_address/out_id/out_channel hold steady while out_valid && !in_ready.
- Latency: a beat accepted at edge N can appear on out_valid in cycle N+1.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.

Optional Feature:
- Macro: CONSUMER_SEQ_CHECK_EN.
- With macro:
  - Adds port seq_error (out, 1).
  - Per channel, each accepted address must equal previous accepted address + 4, mod 2^ADDRESS_WIDTH. The first accept after reset is unchecked.
  - On mismatch, seq_error sets one cycle after the offending accept and is sticky until reset. Flushed beats are still checked.
- Without macro: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package/header (extends defines.vh): ADDRESS_WIDTH, ID_WIDTH, ADDR_STRIDE=4, DROP_COUNT_WIDTH=8, CH1/CH2 channel encodings.
- One sub-module, flush_fifo: DEPTH-entry FIFO with kill bits, push, pop, flush-match-mark and full/empty/count.
- Instantiated twice. Top holds the arbiter, drop counter and sequence checker.

Test Plan:
- Reset then ch1 beats 0x04/0x10, 0x08/0x12 with in_ready=1 -> out 0x04/0x10 then 0x08/0x12, out_channel=0, no stall.
- in_ready=0, ch1 valid continuously, DEPTH=4 -> out_stall_1=1 after 4th accept. Release ready -> 4 beats in order; stall drops the cycle after first pop.
- Both channels full, in_ready=1 -> outputs alternate ch1, ch2, ch1, ch2 starting with ch1.
- ch1 FIFO holds ids 0x12, 0x14, 0x16, 0x18, in_ready=0; pulse flush_1 with id 0x16, then ready=1 -> output 0x12, 0x14, 0x18; drop_count=1.
- flush_1 id 0x16 on the same edge a 0x16 beat is accepted -> beat never output; drop_count increments. Same flush on the edge 0x16 is popped -> beat delivered; drop_count unchanged.
- With CONSUMER_SEQ_CHECK_EN: ch2 addresses 0x04, 0x08, 0x10 -> seq_error=1 from the cycle after the 0x10 accept, held until reset_n low.

Source files
------------

// File: rtl/stream_consumer_pkg.sv
// Shared definitions for the stream consumer: widths, channel encodings,
// the FIFO entry layout and a saturating counter helper.
package stream_consumer_pkg;

  localparam int ADDRESS_WIDTH    = 32;
  localparam int ID_WIDTH         = 8;
  localparam int ADDR_STRIDE      = 4;
  localparam int DROP_COUNT_WIDTH = 8;

  typedef enum logic {
    CH1 = 1'b0,
    CH2 = 1'b1
  } channel_e;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] address;
    logic [ID_WIDTH-1:0]      id;
    logic                     kill;
  } entry_t;

  // Adds 0..2 to the drop counter, sticking at the all-ones value.
  function automatic logic [DROP_COUNT_WIDTH-1:0] sat_add(
    input logic [DROP_COUNT_WIDTH-1:0] value,
    input logic [1:0]                  inc
  );
    logic [DROP_COUNT_WIDTH:0] sum;
    sum = {1'b0, value} + {{(DROP_COUNT_WIDTH-1){1'b0}}, inc};
    return sum[DROP_COUNT_WIDTH] ? '1 : sum[DROP_COUNT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/stream_consumer_flush_fifo.sv
// flush_fifo: DEPTH-entry circular FIFO whose entries carry a kill bit.
// A flush marks every occupied entry with a matching id; a beat pushed on
// the flush edge with a matching id is written already killed.
import stream_consumer_pkg::*;

module flush_fifo #(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [ADDRESS_WIDTH-1:0] push_address,
  input  logic [ID_WIDTH-1:0]      push_id,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [ID_WIDTH-1:0]      flush_id,
  output entry_t                   head,
  output logic [CW-1:0]            count
);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            full;
  logic            empty;
  logic            do_push;
  logic            do_pop;
  logic [DEPTH-1:0] occupied;
  logic [PW-1:0]   offset;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Occupancy mask for flush marking; the entry leaving this edge is excluded.
  always_comb begin
    occupied = '0;
    offset   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset      = PW'(i) - rd_ptr;
      occupied[i] = ({1'b0, offset} < count) && !(do_pop && (PW'(i) == rd_ptr));
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage: write on push, kill-mark on flush.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i].kill <= 1'b0;
    end else begin
      if (flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (occupied[i] && (mem[i].id == flush_id)) mem[i].kill <= 1'b1;
        end
      end
      if (do_push) begin
        mem[wr_ptr] <= '{address: push_address,
                         id:      push_id,
                         kill:    flush && (push_id == flush_id)};
      end
    end
  end

endmodule

// File: rtl/stream_consumer.sv
// stream_consumer: buffers two producer address streams, cancels beats on
// id-matched flush requests and merges the survivors round-robin onto one
// ready/valid output. Optional sequence checker: CONSUMER_SEQ_CHECK_EN.
import stream_consumer_pkg::*;

module stream_consumer #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [ADDRESS_WIDTH-1:0]    in_address_1,
  input  logic [ID_WIDTH-1:0]         in_id_1,
  input  logic                        in_valid_1,
  output logic                        out_stall_1,
  input  logic                        flush_1,
  input  logic [ID_WIDTH-1:0]         flush_id_1,
  input  logic [ADDRESS_WIDTH-1:0]    in_address_2,
  input  logic [ID_WIDTH-1:0]         in_id_2,
  input  logic                        in_valid_2,
  output logic                        out_stall_2,
  input  logic                        flush_2,
  input  logic [ID_WIDTH-1:0]         flush_id_2,
  output logic [ADDRESS_WIDTH-1:0]    out_address,
  output logic [ID_WIDTH-1:0]         out_id,
  output logic                        out_channel,
  output logic                        out_valid,
  input  logic                        in_ready,
`ifdef CONSUMER_SEQ_CHECK_EN
  output logic                        seq_error,
`endif
  output logic [DROP_COUNT_WIDTH-1:0] drop_count
);

  entry_t        head_1, head_2, sel;
  logic [CW-1:0] count_1, count_2;
  logic          live_1, live_2;
  logic          disc_1, disc_2;
  logic          pop_1, pop_2;
  logic          handshake;
  channel_e      grant, last_grant, hold_ch;
  logic          hold_valid;

  flush_fifo #(.DEPTH(DEPTH)) u_fifo_1 (
    .clk          (clk),
    .reset_n      (reset_n),
    .push         (in_valid_1),
    .push_address (in_address_1),
    .push_id      (in_id_1),
    .pop          (pop_1),
    .flush        (flush_1),
    .flush_id     (flush_id_1),
    .head         (head_1),
    .count        (count_1)
  );

  flush_fifo #(.DEPTH(DEPTH)) u_fifo_2 (
    .clk          (clk),
    .reset_n      (reset_n),
    .push         (in_valid_2),
    .push_address (in_address_2),
    .push_id      (in_id_2),
    .pop          (pop_2),
    .flush        (flush_2),
    .flush_id     (flush_id_2),
    .head         (head_2),
    .count        (count_2)
  );

  assign out_stall_1 = (count_1 == CW'(DEPTH));
  assign out_stall_2 = (count_2 == CW'(DEPTH));

  // Arbitration, output mux and pop generation.
  // A beat presented without ready keeps its grant while it stays live, so a
  // newly live channel cannot swap the presented beat out from under the sink.
  always_comb begin
    live_1 = (count_1 != '0) && !head_1.kill;
    live_2 = (count_2 != '0) && !head_2.kill;
    disc_1 = (count_1 != '0) && head_1.kill;
    disc_2 = (count_2 != '0) && head_2.kill;

    if (hold_valid && ((hold_ch == CH1) ? live_1 : live_2)) grant = hold_ch;
    else if (live_1 && live_2) grant = (last_grant == CH1) ? CH2 : CH1;
    else if (live_2)           grant = CH2;
    else                       grant = CH1;

    sel         = (grant == CH2) ? head_2 : head_1;
    out_valid   = (grant == CH2) ? live_2 : live_1;
    out_address = sel.address;
    out_id      = sel.id;
    out_channel = grant;
    handshake   = out_valid && in_ready;
    pop_1       = (handshake && (grant == CH1)) || disc_1;
    pop_2       = (handshake && (grant == CH2)) || disc_2;
  end

  // Round-robin history, grant hold and drop counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant <= CH2;
      hold_valid <= 1'b0;
      hold_ch    <= CH1;
      drop_count <= '0;
    end else begin
      if (handshake) last_grant <= grant;
      hold_valid <= out_valid && !in_ready;
      hold_ch    <= grant;
      drop_count <= sat_add(drop_count, {1'b0, disc_1} + {1'b0, disc_2});
    end
  end

`ifdef CONSUMER_SEQ_CHECK_EN
  logic [ADDRESS_WIDTH-1:0] prev_1, prev_2;
  logic                     have_1, have_2;
  logic                     acc_1, acc_2;

  assign acc_1 = in_valid_1 && !out_stall_1;
  assign acc_2 = in_valid_2 && !out_stall_2;

  // Per-channel stride check on every accepted beat, sticky error flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_1    <= '0;
      prev_2    <= '0;
      have_1    <= 1'b0;
      have_2    <= 1'b0;
      seq_error <= 1'b0;
    end else begin
      if (acc_1) begin
        prev_1 <= in_address_1;
        have_1 <= 1'b1;
        if (have_1 && (in_address_1 != prev_1 + ADDRESS_WIDTH'(ADDR_STRIDE))) seq_error <= 1'b1;
      end
      if (acc_2) begin
        prev_2 <= in_address_2;
        have_2 <= 1'b1;
        if (have_2 && (in_address_2 != prev_2 + ADDRESS_WIDTH'(ADDR_STRIDE))) seq_error <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stream_consumer.sv
// Testbench for stream_consumer: queue-based reference model of the two
// buffered channels, checked every cycle, plus directed scenario checks.
module tb_stream_consumer;
  import stream_consumer_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = ADDRESS_WIDTH;
  localparam int IW    = ID_WIDTH;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] in_address [2];
  logic [IW-1:0] in_id      [2];
  logic          in_valid   [2];
  logic          flush      [2];
  logic [IW-1:0] flush_id   [2];
  logic          in_ready;
  logic          out_stall_1, out_stall_2;
  logic [AW-1:0] out_address;
  logic [IW-1:0] out_id;
  logic          out_channel, out_valid;
  logic [7:0]    drop_count;
`ifdef CONSUMER_SEQ_CHECK_EN
  logic          seq_error;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_consumer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_address_1 (in_address[0]),
    .in_id_1      (in_id[0]),
    .in_valid_1   (in_valid[0]),
    .out_stall_1  (out_stall_1),
    .flush_1      (flush[0]),
    .flush_id_1   (flush_id[0]),
    .in_address_2 (in_address[1]),
    .in_id_2      (in_id[1]),
    .in_valid_2   (in_valid[1]),
    .out_stall_2  (out_stall_2),
    .flush_2      (flush[1]),
    .flush_id_2   (flush_id[1]),
    .out_address  (out_address),
    .out_id       (out_id),
    .out_channel  (out_channel),
    .out_valid    (out_valid),
    .in_ready     (in_ready),
`ifdef CONSUMER_SEQ_CHECK_EN
    .seq_error    (seq_error),
`endif
    .drop_count   (drop_count)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] a;
    logic [IW-1:0] id;
    bit            kill;
  } mbeat_t;

  mbeat_t        mq [2][DEPTH];
  int            msize [2];
  int            m_last;
  bit            m_hold_v;
  int            m_hold_ch;
  int            m_drop;
  bit            m_seq_err;
  bit            m_have [2];
  logic [AW-1:0] m_prev [2];

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    logic          ch;
    logic          stall1;
    logic          stall2;
    logic [7:0]    drop;
`ifdef CONSUMER_SEQ_CHECK_EN
    logic          seq;
`endif
  } snap_t;

  snap_t obs, exp;
  logic [AW-1:0] seen_addr [$];
  logic [IW-1:0] seen_id   [$];
  logic          seen_ch   [$];

  function automatic void model_sel(output bit v, output int g);
    bit live [2];
    for (int c = 0; c < 2; c++) live[c] = (msize[c] > 0) && !mq[c][0].kill;
    if (m_hold_v && live[m_hold_ch]) g = m_hold_ch;
    else if (live[0] && live[1])     g = 1 - m_last;
    else if (live[1])                g = 1;
    else                             g = 0;
    v = live[g];
  endfunction

  function automatic void model_pop(input int c);
    for (int i = 0; i < DEPTH - 1; i++) mq[c][i] = mq[c][i+1];
    msize[c]--;
  endfunction

  function automatic void model_edge();
    bit v;
    int g;
    int nd;
    bit full_pre [2];
    logic [AW-1:0] nxt;
    if (!reset_n) begin
      msize = '{0, 0};
      m_last = 1; m_hold_v = 0; m_hold_ch = 0; m_drop = 0;
      m_seq_err = 0; m_have = '{0, 0};
      return;
    end
    nd = 0;
    model_sel(v, g);
    for (int c = 0; c < 2; c++) full_pre[c] = (msize[c] == DEPTH);
    if (v && in_ready) begin
      model_pop(g);
      m_last = g;
    end
    for (int c = 0; c < 2; c++) begin
      if (!(v && in_ready && g == c) && msize[c] > 0 && mq[c][0].kill) begin
        model_pop(c);
        nd++;
      end
    end
    m_drop    = (m_drop + nd > 255) ? 255 : m_drop + nd;
    m_hold_v  = v && !in_ready;
    m_hold_ch = g;
    for (int c = 0; c < 2; c++) begin
      if (flush[c])
        for (int i = 0; i < msize[c]; i++)
          if (mq[c][i].id == flush_id[c]) mq[c][i].kill = 1;
      if (in_valid[c] && !full_pre[c]) begin
        mq[c][msize[c]] = '{in_address[c], in_id[c], flush[c] && (in_id[c] == flush_id[c])};
        msize[c]++;
        nxt = m_prev[c] + AW'(4);
        if (m_have[c] && in_address[c] != nxt) m_seq_err = 1;
        m_prev[c] = in_address[c];
        m_have[c] = 1;
      end
    end
  endfunction

  // Sample DUT and model away from the edge, then advance both across one edge.
  task automatic tick();
    bit v;
    int g;
    @(negedge clk);
    model_sel(v, g);
    exp = '0;
    exp.valid = v;
    if (v) begin
      exp.addr = mq[g][0].a;
      exp.id   = mq[g][0].id;
      exp.ch   = g[0];
    end
    exp.stall1 = (msize[0] == DEPTH);
    exp.stall2 = (msize[1] == DEPTH);
    exp.drop   = 8'(m_drop);
    obs = '0;
    obs.valid = out_valid;
    if (out_valid) begin
      obs.addr = out_address;
      obs.id   = out_id;
      obs.ch   = out_channel;
    end
    obs.stall1 = out_stall_1;
    obs.stall2 = out_stall_2;
    obs.drop   = drop_count;
`ifdef CONSUMER_SEQ_CHECK_EN
    exp.seq = m_seq_err;
    obs.seq = seq_error;
`endif
    if (out_valid && in_ready) begin
      seen_addr.push_back(out_address);
      seen_id.push_back(out_id);
      seen_ch.push_back(out_channel);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    for (int c = 0; c < 2; c++) begin
      in_address[c] = '0; in_id[c] = '0; in_valid[c] = 0;
      flush[c] = 0; flush_id[c] = '0;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    in_ready = 0;
    reset_n  = 0;
    tick();
    tick();
    reset_n = 1;
    seen_addr.delete(); seen_id.delete(); seen_ch.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    reset_n = 0;
    tick();
    checks++;
    if (obs.valid !== 1'b0 || obs.stall1 !== 1'b0 || obs.stall2 !== 1'b0 || obs.drop !== 8'd0) begin
      failures++;
      $display("FAIL reset: got valid=%0b stall=%0b%0b drop=%0d, expected 0 0 0 0",
               obs.valid, obs.stall1, obs.stall2, obs.drop);
    end
    reset_n = 1;
    tick();
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL reset_model: got %h expected %h", obs, exp); end
  endtask

  task automatic test_basic();
    logic [AW-1:0] ea [2];
    logic [IW-1:0] ei [2];
    ea[0] = 'h04; ea[1] = 'h08; ei[0] = 'h10; ei[1] = 'h12;
    do_reset();
    in_ready = 1;
    for (int k = 0; k < 6; k++) begin
      in_valid[0] = (k < 2);
      in_address[0] = (k < 2) ? ea[k] : '0;
      in_id[0] = (k < 2) ? ei[k] : '0;
      tick();
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL basic cyc%0d: got %h expected %h", k, obs, exp); end
    end
    checks++;
    if (seen_addr.size() != 2) begin
      failures++; $display("FAIL basic_count: got %0d beats expected 2", seen_addr.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (seen_addr[k] !== ea[k] || seen_id[k] !== ei[k] || seen_ch[k] !== 1'b0) begin
          failures++;
          $display("FAIL basic_beat%0d: got %h/%h ch%0b expected %h/%h ch0",
                   k, seen_addr[k], seen_id[k], seen_ch[k], ea[k], ei[k]);
        end
      end
    end
  endtask

  task automatic test_fill_stall();
    int accepted = 0;
    do_reset();
    in_ready = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid[0] = 1;
      in_address[0] = AW'('h100 + 4 * accepted);
      in_id[0] = IW'(accepted);
      tick();
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL fill cyc%0d: got %h expected %h", k, obs, exp); end
      if (!obs.stall1) accepted++;
      if (k == 4) begin
        checks++;
        if (obs.stall1 !== 1'b1) begin failures++; $display("FAIL fill_stall: got %0b expected 1", obs.stall1); end
      end
    end
    in_valid[0] = 0;
    in_ready = 1;
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL drain cyc%0d: got %h expected %h", k, obs, exp); end
      if (k == 1) begin
        checks++;
        if (obs.stall1 !== 1'b0) begin failures++; $display("FAIL drain_stall: got %0b expected 0", obs.stall1); end
      end
    end
    checks++;
    if (seen_addr.size() != 4) begin
      failures++; $display("FAIL drain_count: got %0d beats expected 4", seen_addr.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (seen_addr[k] !== AW'('h100 + 4 * k)) begin
          failures++; $display("FAIL drain_order%0d: got %h expected %h", k, seen_addr[k], AW'('h100 + 4 * k));
        end
      end
    end
  endtask

  task automatic test_alternate();
    do_reset();
    in_ready = 0;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 2; c++) begin
        in_valid[c] = 1; in_address[c] = AW'(4 * (k + 1)); in_id[c] = IW'(16 * c + k);
      end
      tick();
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL alt_fill cyc%0d: got %h expected %h", k, obs, exp); end
    end
    idle_inputs();
    in_ready = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL alt cyc%0d: got %h expected %h", k, obs, exp); end
    end
    checks++;
    if (seen_ch.size() != 8) begin
      failures++; $display("FAIL alt_count: got %0d beats expected 8", seen_ch.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (seen_ch[k] !== 1'(k % 2)) begin
          failures++; $display("FAIL alt_order%0d: got ch%0b expected ch%0d", k, seen_ch[k], k % 2);
        end
      end
    end
  endtask

  task automatic test_flush_buffered();
    logic [IW-1:0] want [3];
    want[0] = 'h12; want[1] = 'h14; want[2] = 'h18;
    do_reset();
    in_ready = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid[0] = 1; in_address[0] = AW'(4 * (k + 1)); in_id[0] = IW'('h12 + 2 * k);
      tick();
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL fb_fill cyc%0d: got %h expected %h", k, obs, exp); end
    end
    idle_inputs();
    flush[0] = 1; flush_id[0] = 'h16;
    tick();
    flush[0] = 0;
    in_ready = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL fb cyc%0d: got %h expected %h", k, obs, exp); end
    end
    checks++;
    if (drop_count !== 8'd1) begin failures++; $display("FAIL fb_drop: got %0d expected 1", drop_count); end
    checks++;
    if (seen_id.size() != 3) begin
      failures++; $display("FAIL fb_count: got %0d beats expected 3", seen_id.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (seen_id[k] !== want[k]) begin
          failures++; $display("FAIL fb_order%0d: got %h expected %h", k, seen_id[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_flush_edge();
    do_reset();
    in_ready = 1;
    in_valid[0] = 1; in_address[0] = 'h04; in_id[0] = 'h16;
    flush[0] = 1; flush_id[0] = 'h16;
    tick();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL fe_arrive cyc%0d: got %h expected %h", k, obs, exp); end
    end
    checks++;
    if (seen_id.size() != 0 || drop_count !== 8'd1) begin
      failures++;
      $display("FAIL fe_arrive: got %0d beats drop=%0d expected 0 beats drop=1", seen_id.size(), drop_count);
    end
    in_ready = 0;
    in_valid[0] = 1; in_address[0] = 'h08; in_id[0] = 'h16;
    tick();
    idle_inputs();
    in_ready = 1;
    flush[0] = 1; flush_id[0] = 'h16;
    tick();
    flush[0] = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL fe_pop cyc%0d: got %h expected %h", k, obs, exp); end
    end
    checks++;
    if (seen_id.size() != 1 || drop_count !== 8'd1) begin
      failures++;
      $display("FAIL fe_pop: got %0d beats drop=%0d expected 1 beat drop=1", seen_id.size(), drop_count);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      reset_n  = (k != 300);
      in_ready = ($urandom_range(0, 9) < 6);
      for (int c = 0; c < 2; c++) begin
        in_valid[c]   = ($urandom_range(0, 9) < 6);
        in_address[c] = AW'($urandom);
        in_id[c]      = IW'($urandom_range('h20, 'h23));
        flush[c]      = ($urandom_range(0, 9) == 0);
        flush_id[c]   = IW'($urandom_range('h20, 'h23));
      end
      tick();
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL random cyc%0d: got %h expected %h", k, obs, exp); end
    end
    reset_n = 1;
    idle_inputs();
  endtask

`ifdef CONSUMER_SEQ_CHECK_EN
  task automatic test_seq();
    logic [AW-1:0] addr [3];
    addr[0] = 'h04; addr[1] = 'h08; addr[2] = 'h10;
    do_reset();
    in_ready = 1;
    for (int k = 0; k < 3; k++) begin
      in_valid[1] = 1; in_address[1] = addr[k]; in_id[1] = IW'(k);
      tick();
      checks++;
      if (obs.seq !== 1'b0) begin failures++; $display("FAIL seq_pre%0d: got %0b expected 0", k, obs.seq); end
    end
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (obs.seq !== 1'b1) begin failures++; $display("FAIL seq_hold%0d: got %0b expected 1", k, obs.seq); end
    end
    reset_n = 0;
    tick();
    reset_n = 1;
    tick();
    checks++;
    if (obs.seq !== 1'b0) begin failures++; $display("FAIL seq_reset: got %0b expected 0", obs.seq); end
  endtask
`endif

  initial begin
    reset_n = 0;
    in_ready = 0;
    idle_inputs();
    test_reset();
    test_basic();
    test_fill_stall();
    test_alternate();
    test_flush_buffered();
    test_flush_edge();
`ifdef CONSUMER_SEQ_CHECK_EN
    test_seq();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
